// File: rtl/ch_trigger_ctrl_pkg.sv
// Chip-level state encoding shared by the channel digital block.
package ch_trigger_ctrl_pkg;
   typedef enum logic [2:0] {
      STATE_STOPPED,
      STATE_INIT,
      STATE_CONFIG,
      STATE_RUN,
      STATE_READOUT
   } state_t;
endpackage

// File: rtl/ch_trigger_ctrl.sv
// Multi-channel trigger controller: synchronises discriminator outputs, detects
// rising hits, combines them (OR/AND/majority) and issues an acknowledged trigger.
module ch_trigger_ctrl
   import ch_trigger_ctrl_pkg::*;
#(
   parameter int unsigned N_CH         = 8,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned FLUSH_CYCLES = 16,
   parameter int unsigned HOLDOFF_W    = 8,
   parameter int unsigned CNT_W        = 10,
   parameter int unsigned THR_W        = $clog2(N_CH + 1)
) (
   input  logic                 FCLK,
   input  logic                 RSTB,
   input  logic                 INST_START,
   input  state_t               current_state,
   input  logic [N_CH-1:0]      DISCRIMINATOR_OUTPUT,
   input  logic [N_CH-1:0]      DISCRIMINATOR_POLARITY,
   input  logic [N_CH-1:0]      CH_ENABLE,
   input  logic [1:0]           TRIG_MODE,
   input  logic [THR_W-1:0]     MAJORITY_THRESH,
   input  logic [HOLDOFF_W-1:0] HOLDOFF_CYCLES,
   input  logic                 TRIG_ACK,
   output logic                 trigger,
   output logic [N_CH-1:0]      trigger_ch,
   output logic [CNT_W-1:0]     trigger_count,
   output logic                 armed
);

   typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_ARMED, S_FIRED, S_HOLDOFF} fsm_t;

   localparam int unsigned FL_W  = $clog2(FLUSH_CYCLES + 1);
   localparam int unsigned TMR_W = (FL_W > HOLDOFF_W) ? FL_W : HOLDOFF_W;
   localparam logic [TMR_W-1:0] FLUSH_LAST = TMR_W'(FLUSH_CYCLES - 1);

   logic [N_CH-1:0]      r_sync [SYNC_STAGES];
   logic [N_CH-1:0]      r_hit;
   logic [N_CH-1:0]      r_hit_d;
   logic                 r_start_d;

   fsm_t                 r_state, w_state_nxt;
   logic [TMR_W-1:0]     r_tmr, w_tmr_nxt;
   logic [HOLDOFF_W-1:0] r_hold_len, w_hold_nxt;
   logic                 r_trig, w_trig_nxt;
   logic [N_CH-1:0]      r_ch, w_ch_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic                 r_armed;

   logic [N_CH-1:0]      w_edge;
   logic [THR_W-1:0]     w_pop;
   logic [THR_W-1:0]     w_thr;
   logic                 w_fire;
   logic                 w_allow;
   logic                 w_start_rise;
   logic [TMR_W-1:0]     w_hold_last;

   // Hit is registered after the synchroniser so a transition reaches the
   // trigger output SYNC_STAGES+1 edges after it is first sampled.
   always_ff @(posedge FCLK or negedge RSTB) begin
      if (!RSTB) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
         r_hit     <= '0;
         r_hit_d   <= '0;
         r_start_d <= 1'b0;
      end else begin
         r_sync[0] <= DISCRIMINATOR_OUTPUT;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_hit     <= (r_sync[SYNC_STAGES-1] ^ DISCRIMINATOR_POLARITY) & CH_ENABLE;
         r_hit_d   <= r_hit;
         r_start_d <= INST_START;
      end
   end

   assign w_edge       = r_hit & ~r_hit_d;
   assign w_start_rise = INST_START & ~r_start_d;
   assign w_allow      = !(current_state inside {STATE_STOPPED, STATE_INIT, STATE_READOUT});
   assign w_thr        = (MAJORITY_THRESH == '0) ? THR_W'(1) : MAJORITY_THRESH;
   assign w_hold_last  = TMR_W'(r_hold_len) - TMR_W'(1);

   always_comb begin
      w_pop = '0;
      for (int unsigned i = 0; i < N_CH; i++) w_pop = w_pop + THR_W'(w_edge[i]);
   end

   always_comb begin
      w_fire = 1'b0;
      case (TRIG_MODE)
         2'd1:    w_fire = (CH_ENABLE != '0) && ((r_hit & CH_ENABLE) == CH_ENABLE) && (|w_edge);
         2'd2:    w_fire = (w_pop >= w_thr);
         default: w_fire = |w_edge;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = r_tmr;
      w_hold_nxt  = r_hold_len;
      w_trig_nxt  = r_trig;
      w_ch_nxt    = r_ch;
      w_cnt_nxt   = r_cnt;
      if (!w_allow) begin
         w_state_nxt = S_IDLE;
         w_trig_nxt  = 1'b0;
      end else if (w_start_rise) begin
         // Restart from IDLE and from any active state share this path.
         w_state_nxt = S_FLUSH;
         w_tmr_nxt   = '0;
         w_trig_nxt  = 1'b0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_FLUSH: begin
               if (r_tmr == FLUSH_LAST) w_state_nxt = S_ARMED;
               else                     w_tmr_nxt   = r_tmr + TMR_W'(1);
            end
            S_ARMED: begin
               if (w_fire) begin
                  w_state_nxt = S_FIRED;
                  w_trig_nxt  = 1'b1;
                  w_ch_nxt    = w_edge;
                  if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_FIRED: begin
               if (TRIG_ACK) begin
                  w_trig_nxt = 1'b0;
                  if (HOLDOFF_CYCLES == '0) begin
                     w_state_nxt = S_ARMED;
                  end else begin
                     w_state_nxt = S_HOLDOFF;
                     w_tmr_nxt   = '0;
                     w_hold_nxt  = HOLDOFF_CYCLES;
                  end
               end
            end
            S_HOLDOFF: begin
               if (r_tmr == w_hold_last) w_state_nxt = S_ARMED;
               else                      w_tmr_nxt   = r_tmr + TMR_W'(1);
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge FCLK or negedge RSTB) begin
      if (!RSTB) begin
         r_state    <= S_IDLE;
         r_tmr      <= '0;
         r_hold_len <= '0;
         r_trig     <= 1'b0;
         r_ch       <= '0;
         r_cnt      <= '0;
         r_armed    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tmr      <= w_tmr_nxt;
         r_hold_len <= w_hold_nxt;
         r_trig     <= w_trig_nxt;
         r_ch       <= w_ch_nxt;
         r_cnt      <= w_cnt_nxt;
         r_armed    <= (w_state_nxt == S_ARMED);
      end
   end

   assign trigger       = r_trig;
   assign trigger_ch    = r_ch;
   assign trigger_count = r_cnt;
   assign armed         = r_armed;

endmodule

// File: tb/tb_ch_trigger_ctrl.sv
// Testbench for ch_trigger_ctrl: vector table, directed corner sequences and a
// randomized run against a cycle-level reference model.
module tb_ch_trigger_ctrl;
   import ch_trigger_ctrl_pkg::*;

   localparam int N_CH = 8, SYNC = 2, FLUSH = 16, HW = 8, CW = 10, TW = 4;

   logic          FCLK = 1'b0, RSTB = 1'b0, INST_START = 1'b0, TRIG_ACK = 1'b0;
   state_t        cs = STATE_RUN;
   logic [7:0]    DISC = '0, POL = '0, EN = 8'hff, HOLD = '0;
   logic [1:0]    MODE = '0;
   logic [TW-1:0] THR = '0;
   logic          trigger, armed;
   logic [7:0]    trigger_ch;
   logic [9:0]    trigger_count;
   int            n_tests = 0, n_fail = 0;

   ch_trigger_ctrl #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .FLUSH_CYCLES(FLUSH),
                     .HOLDOFF_W(HW), .CNT_W(CW), .THR_W(TW)) dut (
      .FCLK(FCLK), .RSTB(RSTB), .INST_START(INST_START), .current_state(cs),
      .DISCRIMINATOR_OUTPUT(DISC), .DISCRIMINATOR_POLARITY(POL), .CH_ENABLE(EN),
      .TRIG_MODE(MODE), .MAJORITY_THRESH(THR), .HOLDOFF_CYCLES(HOLD),
      .TRIG_ACK(TRIG_ACK), .trigger(trigger), .trigger_ch(trigger_ch),
      .trigger_count(trigger_count), .armed(armed));

   always #5 FCLK = ~FCLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge FCLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      RSTB = 1'b0; TRIG_ACK = 1'b0; INST_START = 1'b0;
      tick(); tick();
      RSTB = 1'b1;
   endtask

   task automatic start_acq();
      INST_START = 1'b1; tick(); INST_START = 1'b0;
      repeat (FLUSH) tick();
   endtask

   task automatic wait_trig(input int lim);
      int k = 0;
      while (trigger !== 1'b1 && k < lim) begin tick(); k++; end
      if (trigger !== 1'b1) chk("wait_trig_timeout", 32'(trigger), 32'd1);
   endtask

   // ---------------- reference model ----------------
   logic [7:0] dh [int];
   int         m_n, m_wait, m_ph;  // phase: 0 idle, 1 flush, 2 armed, 3 fired, 4 holdoff
   logic       m_sp, m_trig;
   logic [7:0] m_ch;
   int         m_cnt;

   function automatic logic [7:0] mh(input int m);
      logic [7:0] s;
      if (m <= 0) return 8'h00;
      s = (m - SYNC >= 1) ? dh[m-SYNC] : 8'h00;
      return (s ^ POL) & EN;
   endfunction

   task automatic model_reset();
      dh.delete();
      m_n = 0; m_wait = 0; m_ph = 0; m_sp = 1'b0; m_trig = 1'b0; m_ch = '0; m_cnt = 0;
   endtask

   task automatic model_step();
      logic [7:0] cur, edges;
      logic comb, allow, rise;
      int th;
      m_n++;
      dh[m_n] = DISC;
      cur   = mh(m_n - 1);
      edges = cur & ~mh(m_n - 2);
      th    = (THR == 0) ? 1 : int'(THR);
      case (MODE)
         2'd1:    comb = (EN != 0) && (cur == EN) && (edges != 0);
         2'd2:    comb = ($countones(edges) >= th);
         default: comb = (edges != 0);
      endcase
      allow = !(cs inside {STATE_STOPPED, STATE_INIT, STATE_READOUT});
      rise  = INST_START && !m_sp;
      m_sp  = INST_START;
      if (!allow) begin
         m_ph = 0; m_trig = 1'b0;
      end else if (rise) begin
         m_ph = 1; m_wait = FLUSH; m_trig = 1'b0; m_cnt = 0;
      end else if (m_ph == 1 || m_ph == 4) begin
         m_wait--;
         if (m_wait == 0) m_ph = 2;
      end else if (m_ph == 2 && comb) begin
         m_ph = 3; m_trig = 1'b1; m_ch = edges;
         m_cnt = (m_cnt < 1023) ? m_cnt + 1 : 1023;
      end else if (m_ph == 3 && TRIG_ACK) begin
         m_trig = 1'b0;
         if (HOLD == 0) m_ph = 2;
         else begin m_ph = 4; m_wait = int'(HOLD); end
      end
   endtask

   typedef struct packed {
      logic [1:0]    mode;
      logic [TW-1:0] thr;
      logic [7:0]    en, pol, base, pat;
      logic          fire;
      logic [7:0]    ch;
   } vec_t;
   vec_t vt [12];

   initial begin
      vt[0]  = '{2'd0, 4'd0, 8'hff, 8'h00, 8'h00, 8'h01, 1'b1, 8'h01};
      vt[1]  = '{2'd0, 4'd0, 8'hff, 8'h04, 8'h04, 8'h00, 1'b1, 8'h04};
      vt[2]  = '{2'd0, 4'd0, 8'hfb, 8'h04, 8'h04, 8'h00, 1'b0, 8'h00};
      vt[3]  = '{2'd0, 4'd0, 8'hff, 8'h00, 8'h08, 8'h08, 1'b0, 8'h00};
      vt[4]  = '{2'd2, 4'd3, 8'hff, 8'h00, 8'h00, 8'h22, 1'b0, 8'h00};
      vt[5]  = '{2'd2, 4'd3, 8'hff, 8'h00, 8'h00, 8'h62, 1'b1, 8'h62};
      vt[6]  = '{2'd1, 4'd0, 8'h03, 8'h00, 8'h01, 8'h03, 1'b1, 8'h02};
      vt[7]  = '{2'd1, 4'd0, 8'h00, 8'h00, 8'h00, 8'hff, 1'b0, 8'h00};
      vt[8]  = '{2'd2, 4'd0, 8'hff, 8'h00, 8'h00, 8'h10, 1'b1, 8'h10};
      vt[9]  = '{2'd3, 4'd0, 8'hff, 8'h00, 8'h00, 8'h80, 1'b1, 8'h80};
      vt[10] = '{2'd1, 4'd0, 8'h03, 8'h00, 8'h00, 8'h01, 1'b0, 8'h00};
      vt[11] = '{2'd2, 4'd8, 8'hff, 8'h00, 8'h00, 8'hff, 1'b1, 8'hff};

      // ---- combine table ----
      for (int i = 0; i < 12; i++) begin
         MODE = vt[i].mode; THR = vt[i].thr; EN = vt[i].en; POL = vt[i].pol;
         DISC = vt[i].base;
         do_reset();
         start_acq();
         chk($sformatf("vec%0d_armed", i), 32'(armed), 32'd1);
         DISC = vt[i].pat;
         repeat (3) tick();
         chk($sformatf("vec%0d_early", i), 32'(trigger), 32'd0);
         tick();
         chk($sformatf("vec%0d_trig", i), 32'(trigger), 32'(vt[i].fire));
         chk($sformatf("vec%0d_ch", i), 32'(trigger_ch), 32'(vt[i].ch));
         chk($sformatf("vec%0d_cnt", i), 32'(trigger_count), 32'(vt[i].fire));
      end

      // ---- async reset while FIRED, then arming delay ----
      MODE = 2'd0; THR = '0; EN = 8'hff; POL = 8'h00; DISC = 8'h00; HOLD = 8'd0;
      do_reset();
      chk("rst_trig", 32'(trigger), 32'd0);
      chk("rst_armed", 32'(armed), 32'd0);
      start_acq();
      DISC = 8'h01;
      repeat (4) tick();
      chk("pre_rst_trig", 32'(trigger), 32'd1);
      #2 RSTB = 1'b0;
      #1;
      chk("async_rst", 32'({trigger, armed, trigger_ch, trigger_count}), 32'd0);
      tick();
      RSTB = 1'b1; DISC = 8'h00;
      INST_START = 1'b1; tick(); INST_START = 1'b0;
      repeat (15) tick();
      chk("arm_at_15", 32'(armed), 32'd0);
      tick();
      chk("arm_at_16", 32'(armed), 32'd1);

      // ---- flush window and latency ----
      do_reset();
      INST_START = 1'b1; tick(); INST_START = 1'b0;
      repeat (4) tick();
      DISC = 8'h01; tick(); DISC = 8'h00;
      repeat (11) tick();
      chk("flush_armed", 32'(armed), 32'd1);
      chk("flush_no_trig", 32'(trigger), 32'd0);
      repeat (3) tick();
      chk("flush_late_trig", 32'(trigger), 32'd0);
      DISC = 8'h01;
      repeat (3) tick();
      chk("lat_edge3", 32'(trigger), 32'd0);
      tick();
      chk("lat_edge4", 32'(trigger), 32'd1);
      chk("lat_ch", 32'(trigger_ch), 32'h01);
      chk("lat_cnt", 32'(trigger_count), 32'd1);

      // ---- acknowledge with holdoff 4, edge inside holdoff ----
      HOLD = 8'd4;
      DISC = 8'h00; tick(); tick();
      DISC = 8'h01; tick();
      TRIG_ACK = 1'b1; tick(); TRIG_ACK = 1'b0; HOLD = 8'd9;
      chk("ack_trig_low", 32'(trigger), 32'd0);
      chk("ack_ch_kept", 32'(trigger_ch), 32'h01);
      repeat (3) tick();
      chk("hold_armed_3", 32'(armed), 32'd0);
      tick();
      chk("hold_armed_4", 32'(armed), 32'd1);
      repeat (4) tick();
      chk("hold_edge_ignored", 32'(trigger), 32'd0);

      // ---- holdoff 0 ----
      HOLD = 8'd0;
      DISC = 8'h00; tick(); tick();
      DISC = 8'h01; repeat (4) tick();
      chk("h0_trig", 32'(trigger), 32'd1);
      chk("h0_cnt", 32'(trigger_count), 32'd2);
      TRIG_ACK = 1'b1; tick(); TRIG_ACK = 1'b0;
      chk("h0_trig_low", 32'(trigger), 32'd0);
      chk("h0_armed", 32'(armed), 32'd1);

      // ---- state gating while FIRED with concurrent ACK ----
      DISC = 8'h00; tick(); tick();
      DISC = 8'h01; repeat (4) tick();
      chk("gate_fired", 32'(trigger), 32'd1);
      cs = STATE_READOUT; TRIG_ACK = 1'b1; tick();
      chk("gate_trig", 32'(trigger), 32'd0);
      chk("gate_armed", 32'(armed), 32'd0);
      chk("gate_cnt_kept", 32'(trigger_count), 32'd3);
      chk("gate_ch_kept", 32'(trigger_ch), 32'h01);
      cs = STATE_RUN; TRIG_ACK = 1'b0;
      repeat (3) tick();
      chk("gate_idle", 32'(armed), 32'd0);
      INST_START = 1'b1; tick(); INST_START = 1'b0;
      chk("restart_cnt_clr", 32'(trigger_count), 32'd0);

      // ---- counter saturation ----
      HOLD = 8'd0; DISC = 8'h00;
      do_reset();
      start_acq();
      for (int i = 0; i < 1025; i++) begin
         DISC = 8'h01;
         wait_trig(10);
         if (i == 1021) chk("sat_1022", 32'(trigger_count), 32'h3fe);
         if (i == 1022) chk("sat_1023", 32'(trigger_count), 32'h3ff);
         TRIG_ACK = 1'b1; tick(); TRIG_ACK = 1'b0;
         DISC = 8'h00; tick(); tick();
      end
      chk("sat_final", 32'(trigger_count), 32'h3ff);

      // ---- randomized run against the model ----
      POL = 8'($urandom); EN = 8'($urandom_range(1, 255)); DISC = 8'h00;
      MODE = 2'd0; THR = '0; HOLD = 8'd2; cs = STATE_RUN;
      do_reset();
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) DISC[b] = ~DISC[b];
         if ($urandom_range(0, 99) == 0) begin
            MODE = 2'($urandom);
            THR  = 4'($urandom_range(0, 8));
            HOLD = 8'($urandom_range(0, 5));
         end
         TRIG_ACK   = ($urandom_range(0, 3) == 0);
         INST_START = ($urandom_range(0, 79) == 0);
         case ($urandom_range(0, 199))
            0:       cs = STATE_READOUT;
            1:       cs = STATE_STOPPED;
            2:       cs = STATE_INIT;
            3:       cs = STATE_CONFIG;
            default: cs = STATE_RUN;
         endcase
         model_step();
         tick();
         chk($sformatf("rand_c%0d", c),
             32'({trigger, armed, trigger_ch, trigger_count}),
             32'({m_trig, (m_ph == 2), m_ch, 10'(m_cnt)}));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
